// File: rtl/inv_s_box_seq.sv
// Sequential AES InvSubBytes: BYTES_PER_CYCLE bytes per cycle through a shared inverse S-box LUT.
// Optional synchronous abort port enabled by defining INV_SBOX_FLUSH_EN.
module inv_s_box_seq #(
   parameter int BYTES_PER_CYCLE = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] inputData,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] invSubData,
   output logic         busy
`ifdef INV_SBOX_FLUSH_EN
   ,
   input  logic         flush
`endif
);

   localparam int NSTEP = 16 / BYTES_PER_CYCLE;
   localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
   localparam int SLICE = 8 * BYTES_PER_CYCLE;

   generate
      if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
            BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
         $error("inv_s_box_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   localparam logic [7:0] INV_SBOX [0:255] = '{
      8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
      8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
      8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
      8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
      8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
      8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
      8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
      8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
      8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
      8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
      8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
      8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
      8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
      8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
      8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
      8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
   };

   typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

   state_t                                 state;
   logic [CW-1:0]                          cnt;
   logic [127:0]                           src_reg;
   logic [127:0]                           res_reg;
   logic [6:0]                             base;
   logic [BYTES_PER_CYCLE-1:0][7:0]        sub_bytes;
   logic                                   abort;

`ifdef INV_SBOX_FLUSH_EN
   assign abort = flush;
`else
   assign abort = 1'b0;
`endif

   assign in_ready   = (state == IDLE);
   assign busy       = (state != IDLE);
   assign invSubData = res_reg;

   // Bit offset of the slice handled this step.
   assign base = 7'(int'(cnt) * SLICE);

   always_comb begin
      sub_bytes = '0;
      for (int b = 0; b < BYTES_PER_CYCLE; b++)
         sub_bytes[b] = INV_SBOX[src_reg[int'(base) + 8*b +: 8]];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         src_reg   <= '0;
         res_reg   <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // A same-cycle abort suppresses acceptance.
               if (in_valid && !abort) begin
                  src_reg <= inputData;
                  cnt     <= '0;
                  state   <= SUB;
               end
            end
            SUB: begin
               if (abort) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  res_reg[base +: SLICE] <= sub_bytes;
                  if (cnt == CW'(NSTEP - 1)) begin
                     cnt       <= '0;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            DONE: begin
               if (abort || out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inv_s_box_seq.sv
// Bench for inv_s_box_seq at BPC 4, 1 and 16; reference inverse S-box is derived
// from GF(2^8) inversion plus the AES affine map.
module tb_inv_s_box_seq;

   localparam int NI = 3;
   localparam int BPCS [NI] = '{4, 1, 16};

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid   [NI];
   logic         in_ready   [NI];
   logic [127:0] inputData  [NI];
   logic         out_valid  [NI];
   logic         out_ready  [NI];
   logic [127:0] invSubData [NI];
   logic         busy       [NI];
`ifdef INV_SBOX_FLUSH_EN
   logic         flush      [NI];
`endif

   int vectors    = 0;
   int miscompares = 0;

   logic [7:0] fwd_sb [256];
   logic [7:0] inv_sb [256];

   always #5 clk = ~clk;

   generate
      for (genvar g = 0; g < NI; g++) begin : g_dut
         inv_s_box_seq #(.BYTES_PER_CYCLE(BPCS[g])) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid[g]),
            .in_ready   (in_ready[g]),
            .inputData  (inputData[g]),
            .out_valid  (out_valid[g]),
            .out_ready  (out_ready[g]),
            .invSubData (invSubData[g]),
            .busy       (busy[g])
`ifdef INV_SBOX_FLUSH_EN
            ,
            .flush      (flush[g])
`endif
         );
      end
   endgenerate

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
      logic [7:0] r = v;
      for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
      return r;
   endfunction

   function automatic logic [127:0] model(input logic [127:0] d);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_sb[d[8*i +: 8]];
      return r;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One full transaction on instance k; out_ready held low for 'hold' cycles in DONE.
   task automatic xact(input int k, input logic [127:0] d, input logic [127:0] exp, input int hold);
      int lat;
      out_ready[k] = (hold == 0);
      in_valid[k]  = 1'b1;
      inputData[k] = d;
      chk("in_ready_before_accept", 128'(in_ready[k]), 128'd1);
      @(posedge clk); #1;
      in_valid[k]  = 1'b0;
      inputData[k] = rnd128();
      lat = 0;
      while (!out_valid[k] && lat < 64) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", 128'(lat), 128'(16 / BPCS[k]));
      chk("data", invSubData[k], exp);
      chk("busy_done", 128'(busy[k]), 128'd1);
      if (hold > 0) begin
         in_valid[k]  = 1'b1;
         inputData[k] = rnd128();
         for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            chk("hold_valid", 128'(out_valid[k]), 128'd1);
            chk("hold_data", invSubData[k], exp);
            chk("hold_in_ready", 128'(in_ready[k]), 128'd0);
         end
         in_valid[k]  = 1'b0;
         out_ready[k] = 1'b1;
      end
      @(posedge clk); #1;
      chk("valid_drop", 128'(out_valid[k]), 128'd0);
      chk("in_ready_after", 128'(in_ready[k]), 128'd1);
      chk("busy_after", 128'(busy[k]), 128'd0);
   endtask

   initial begin
      logic [127:0] d, e;
      logic [7:0]   inv;

      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++)
            if (gmul(8'(x), 8'(b)) == 8'h01) inv = 8'(b);
         fwd_sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
         inv_sb[fwd_sb[x]] = 8'(x);
      end

      for (int k = 0; k < NI; k++) begin
         in_valid[k] = 1'b0; inputData[k] = '0; out_ready[k] = 1'b1;
`ifdef INV_SBOX_FLUSH_EN
         flush[k] = 1'b0;
`endif
      end

      #12;
      for (int k = 0; k < NI; k++) begin
         chk("rst_in_ready", 128'(in_ready[k]), 128'd1);
         chk("rst_out_valid", 128'(out_valid[k]), 128'd0);
         chk("rst_data", invSubData[k], 128'd0);
         chk("rst_busy", 128'(busy[k]), 128'd0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      xact(0, {16{8'h63}}, 128'd0, 0);
      xact(0, {{12{8'h63}}, 8'hED, 8'h16, 8'h00, 8'h7C},
              {{12{8'h00}}, 8'h53, 8'hFF, 8'h52, 8'h01}, 0);
      d = rnd128();
      xact(0, d, model(d), 10);

      for (int j = 0; j < 16; j++) begin
         for (int i = 0; i < 16; i++) begin
            d[8*i +: 8] = fwd_sb[16*j + i];
            e[8*i +: 8] = 8'(16*j + i);
         end
         xact(0, d, e, 0);
      end

      // Reset during the second SUB cycle.
      in_valid[0] = 1'b1; inputData[0] = rnd128(); out_ready[0] = 1'b1;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", 128'(out_valid[0]), 128'd0);
      chk("midrst_data", invSubData[0], 128'd0);
      chk("midrst_in_ready", 128'(in_ready[0]), 128'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      d = rnd128();
      xact(0, d, model(d), 0);

      for (int k = 1; k < NI; k++) xact(k, {16{8'h52}}, {16{8'h48}}, 0);

      for (int n = 0; n < 6; n++) begin
         for (int k = 0; k < NI; k++) begin
            d = rnd128();
            xact(k, d, model(d), int'($urandom_range(0, 3)));
         end
      end

`ifdef INV_SBOX_FLUSH_EN
      in_valid[2] = 1'b1; inputData[2] = rnd128(); out_ready[2] = 1'b0;
      @(posedge clk); #1;
      in_valid[2] = 1'b0;
      @(posedge clk); #1;
      chk("flush_pre_valid", 128'(out_valid[2]), 128'd1);
      flush[2] = 1'b1;
      @(posedge clk); #1;
      flush[2] = 1'b0;
      chk("flush_out_valid", 128'(out_valid[2]), 128'd0);
      chk("flush_in_ready", 128'(in_ready[2]), 128'd1);
      out_ready[2] = 1'b1;
      d = rnd128();
      xact(2, d, model(d), 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
